// File: rtl/pulpino_rst_seq.sv
// Reset and boot sequencer for the PULPino FPGA build: conditions MMCM lock and the reset
// button, then releases the core reset followed by fetch enable after a programmable delay.
module pulpino_rst_seq #(
  parameter int unsigned SYNC_STAGES         = 2,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned BTN_DEBOUNCE_CYCLES = 65536,
  parameter int unsigned FETCH_DELAY_CYCLES  = 16
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       locked_i,
  input  logic       ck_rst_i,
  output logic       rst_n_o,
  output logic       fetch_enable_o,
  output logic [1:0] state_o,
  output logic [1:0] rst_cause_o,
  output logic [7:0] rst_count_o
);

  localparam int unsigned MaxCnt = (LOCK_STABLE_CYCLES > FETCH_DELAY_CYCLES) ?
                                   LOCK_STABLE_CYCLES : FETCH_DELAY_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);
  localparam int unsigned DbW    = $clog2(BTN_DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    StHold    = 2'd0,
    StWait    = 2'd1,
    StRelease = 2'd2,
    StRun     = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] lock_sync;
  logic [SYNC_STAGES-1:0] btn_sync;
  logic                   lock_s;
  logic                   btn_press_s;
  logic [DbW-1:0]         db_cnt;
  logic                   btn_db;
  logic                   ok;
  state_e                 state;
  logic [CntW-1:0]        cnt;

  // Button chain resets to the released level so a reset never looks like a press.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      lock_sync <= '0;
      btn_sync  <= '1;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], locked_i};
      btn_sync  <= {btn_sync[SYNC_STAGES-2:0], ck_rst_i};
    end
  end

  assign lock_s      = lock_sync[SYNC_STAGES-1];
  assign btn_press_s = ~btn_sync[SYNC_STAGES-1];

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      db_cnt <= '0;
      btn_db <= 1'b0;
    end else if (btn_press_s != btn_db) begin
      if (db_cnt == DbW'(BTN_DEBOUNCE_CYCLES - 1)) begin
        btn_db <= btn_press_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  assign ok = lock_s & ~btn_db;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state          <= StHold;
      cnt            <= '0;
      rst_n_o        <= 1'b0;
      fetch_enable_o <= 1'b0;
      rst_cause_o    <= 2'd0;
      rst_count_o    <= 8'd0;
    end else begin
      unique case (state)
        StHold: begin
          if (ok) begin
            state <= StWait;
            cnt   <= '0;
          end
        end
        StWait: begin
          if (!ok) begin
            state <= StHold;
            cnt   <= '0;
          end else if (cnt == CntW'(LOCK_STABLE_CYCLES - 1)) begin
            state   <= StRelease;
            cnt     <= '0;
            rst_n_o <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StRelease, StRun: begin
          if (!ok) begin
            // Lock loss takes precedence over the button as the recorded cause.
            state          <= StHold;
            cnt            <= '0;
            rst_n_o        <= 1'b0;
            fetch_enable_o <= 1'b0;
            rst_cause_o    <= lock_s ? 2'd2 : 2'd1;
            if (rst_count_o != 8'hFF) rst_count_o <= rst_count_o + 8'd1;
          end else if (state == StRelease) begin
            if (cnt == CntW'(FETCH_DELAY_CYCLES - 1)) begin
              state          <= StRun;
              cnt            <= '0;
              fetch_enable_o <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= StHold;
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_pulpino_rst_seq.sv
// Bench for pulpino_rst_seq: vector table for power-up, directed corner sequences and random
// stimulus, all checked against a run-length based reference model.
module tb_pulpino_rst_seq;

  localparam int S = 2;
  localparam int L = 8;
  localparam int B = 4;
  localparam int F = 3;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked_i = 1'b0;
  logic       ck_rst_i = 1'b1;
  logic       rst_n_o;
  logic       fetch_enable_o;
  logic [1:0] state_o;
  logic [1:0] rst_cause_o;
  logic [7:0] rst_count_o;

  always #5 sys_clk = ~sys_clk;

  pulpino_rst_seq #(
    .SYNC_STAGES        (S),
    .LOCK_STABLE_CYCLES (L),
    .BTN_DEBOUNCE_CYCLES(B),
    .FETCH_DELAY_CYCLES (F)
  ) dut (
    .sys_clk       (sys_clk),
    .rst           (rst),
    .locked_i      (locked_i),
    .ck_rst_i      (ck_rst_i),
    .rst_n_o       (rst_n_o),
    .fetch_enable_o(fetch_enable_o),
    .state_o       (state_o),
    .rst_cause_o   (rst_cause_o),
    .rst_count_o   (rst_count_o)
  );

  int passed = 0;
  int total  = 0;
  logic cur_locked = 1'b0;
  logic cur_btn    = 1'b1;

  // Reference model: the sequencer state follows from how long "ok" has held continuously.
  logic lock_q[$];
  logic btn_q[$];
  logic win[$];
  logic m_db;
  int   m_run;
  int   m_cause;
  int   m_count;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
  endtask

  task automatic model_reset();
    lock_q = {};
    btn_q  = {};
    win    = {};
    for (int i = 0; i < S; i++) begin
      lock_q.push_back(1'b0);
      btn_q.push_back(1'b0);
    end
    m_db = 1'b0; m_run = 0; m_cause = 0; m_count = 0;
  endtask

  task automatic model_edge(input logic r, input logic l, input logic b);
    logic ls, bs, all_diff;
    if (r) begin
      model_reset();
      return;
    end
    ls = lock_q[0];
    bs = btn_q[0];
    if (ls && !m_db) m_run++;
    else begin
      if (m_run > L) begin
        m_cause = ls ? 2 : 1;
        if (m_count < 255) m_count++;
      end
      m_run = 0;
    end
    // Debounced level flips once the last B synchronized samples all disagree with it.
    win.push_back(bs);
    if (win.size() > B) void'(win.pop_front());
    if (win.size() == B) begin
      all_diff = 1'b1;
      foreach (win[i]) if (win[i] == m_db) all_diff = 1'b0;
      if (all_diff) m_db = !m_db;
    end
    lock_q.push_back(l);
    void'(lock_q.pop_front());
    btn_q.push_back(!b);
    void'(btn_q.pop_front());
  endtask

  function automatic int m_state();
    if (m_run == 0) return 0;
    if (m_run <= L) return 1;
    if (m_run <= L + F) return 2;
    return 3;
  endfunction

  task automatic step(input logic r);
    rst = r; locked_i = cur_locked; ck_rst_i = cur_btn;
    @(posedge sys_clk);
    model_edge(r, cur_locked, cur_btn);
    #1;
    check("model rst_n", int'(rst_n_o), int'(m_run > L));
    check("model fetch_enable", int'(fetch_enable_o), int'(m_run > L + F));
    check("model state", int'(state_o), m_state());
    check("model rst_cause", int'(rst_cause_o), m_cause);
    check("model rst_count", int'(rst_count_o), m_count);
    check("fetch without rst_n", int'(fetch_enable_o && !rst_n_o), 0);
  endtask

  task automatic run_until(input logic [1:0] st, output int n);
    n = 0;
    while (state_o != st && n < 200) begin
      step(1'b0);
      n++;
    end
    check("reach state", int'(state_o), int'(st));
  endtask

  typedef struct {
    logic       r;
    logic       l;
    logic       b;
    logic       exp_rst_n;
    logic       exp_fe;
    logic [1:0] exp_state;
    logic [7:0] exp_count;
  } vec_t;

  vec_t tbl[20];

  initial begin
    int n;
    model_reset();

    // Power-up: 3 reset cycles, then lock sampled high from edge k (row 3).
    for (int i = 0; i < 20; i++) begin
      int j;
      j = i - 3;
      if (i < 3) tbl[i] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};
      else begin
        tbl[i].r = 1'b0; tbl[i].l = 1'b1; tbl[i].b = 1'b1;
        tbl[i].exp_rst_n = (j >= 10);
        tbl[i].exp_fe    = (j >= 13);
        tbl[i].exp_state = (j < 2) ? 2'd0 : (j < 10) ? 2'd1 : (j < 13) ? 2'd2 : 2'd3;
        tbl[i].exp_count = 8'd0;
      end
    end
    for (int i = 0; i < 20; i++) begin
      cur_locked = tbl[i].l;
      cur_btn    = tbl[i].b;
      step(tbl[i].r);
      check("pwr rst_n", int'(rst_n_o), int'(tbl[i].exp_rst_n));
      check("pwr fetch_enable", int'(fetch_enable_o), int'(tbl[i].exp_fe));
      check("pwr state", int'(state_o), int'(tbl[i].exp_state));
      check("pwr rst_count", int'(rst_count_o), int'(tbl[i].exp_count));
    end

    // Lock flicker during WAIT at cnt=5: restart the full count, no reset recorded.
    cur_locked = 1'b0;
    step(1'b1);
    step(1'b1);
    cur_locked = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b0);
    check("flicker in wait", int'(state_o), 1);
    cur_locked = 1'b0;
    step(1'b0);
    cur_locked = 1'b1;
    step(1'b0);
    check("flicker still wait", int'(state_o), 1);
    step(1'b0);
    check("flicker to hold", int'(state_o), 0);
    run_until(2'd2, n);
    check("flicker recount", n, 9);
    check("flicker count", int'(rst_count_o), 0);
    run_until(2'd3, n);

    // Lock loss in RUN.
    cur_locked = 1'b0;
    step(1'b0);
    step(1'b0);
    check("lockloss k+1 rst_n", int'(rst_n_o), 1);
    step(1'b0);
    check("lockloss rst_n", int'(rst_n_o), 0);
    check("lockloss fetch", int'(fetch_enable_o), 0);
    check("lockloss cause", int'(rst_cause_o), 1);
    check("lockloss count", int'(rst_count_o), 1);
    cur_locked = 1'b1;
    run_until(2'd3, n);
    check("relock cycles", n, 14);

    // Button: short glitch ignored, held press resets the core.
    cur_btn = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0);
    cur_btn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      check("glitch rst_n", int'(rst_n_o), 1);
      check("glitch fetch", int'(fetch_enable_o), 1);
    end
    cur_btn = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b0);
    check("btn k+5 rst_n", int'(rst_n_o), 1);
    step(1'b0);
    check("btn rst_n", int'(rst_n_o), 0);
    check("btn fetch", int'(fetch_enable_o), 0);
    check("btn cause", int'(rst_cause_o), 2);
    check("btn count", int'(rst_count_o), 2);
    cur_btn = 1'b1;
    run_until(2'd3, n);
    check("btn release cycles", n, 18);

    // Lock loss and button press together while in RELEASE.
    cur_locked = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0);
    cur_locked = 1'b1;
    run_until(2'd2, n);
    cur_locked = 1'b0;
    cur_btn    = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0);
    check("both state", int'(state_o), 0);
    check("both cause", int'(rst_cause_o), 1);
    check("both count", int'(rst_count_o), 4);
    for (int i = 0; i < 6; i++) step(1'b0);
    check("both count once", int'(rst_count_o), 4);
    cur_locked = 1'b1;
    cur_btn    = 1'b1;

    // Saturation of the reset counter.
    for (int i = 0; i < 260; i++) begin
      cur_locked = 1'b1;
      run_until(2'd2, n);
      cur_locked = 1'b0;
      for (int j = 0; j < 3; j++) step(1'b0);
    end
    check("sat count", int'(rst_count_o), 255);

    // Reset asserted mid-RELEASE.
    cur_locked = 1'b1;
    run_until(2'd2, n);
    step(1'b1);
    check("rst rst_n", int'(rst_n_o), 0);
    check("rst fetch", int'(fetch_enable_o), 0);
    check("rst state", int'(state_o), 0);
    check("rst cause", int'(rst_cause_o), 0);
    check("rst count", int'(rst_count_o), 0);

    // Random stimulus against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(39) == 0) cur_locked = !cur_locked;
      if ($urandom_range(29) == 0) cur_btn = !cur_btn;
      step($urandom_range(599) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
